// File: rtl/ro_pair_counter.sv
// ============================================================================
// Module      : ro_pair_counter
// Description : Gates a ring-oscillator pair, counts edges of each output over
//               a programmable window and returns one comparison bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_pair_counter #(
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       chal,
    input  logic [WIN_W-1:0] window,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_en,
    output logic [3:0]       ro_c,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [WIN_W-1:0] SETTLE_M1 = WIN_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        COUNT  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             ro_en_q, ro_en_d;
    logic [3:0]       ro_c_q, ro_c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             resp_q, resp_d;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             sync_a1_q, sync_a2_q, prev_a_q;
    logic             sync_b1_q, sync_b2_q, prev_b_q;
    logic             edge_a, edge_b;

    assign edge_a = sync_a2_q & ~prev_a_q;
    assign edge_b = sync_b2_q & ~prev_b_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        win_d   = win_q;
        ro_en_d = ro_en_q;
        ro_c_d  = ro_c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        resp_d  = resp_q;
        tie_d   = tie_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ro_c_d  = chal;
                    win_d   = window;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    ro_en_d = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = SETTLE_M1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (timer_q == '0) begin
                    if (win_q == '0) begin
                        ro_en_d = 1'b0;
                        state_d = RESULT;
                    end else begin
                        timer_d = win_q - WIN_W'(1);
                        state_d = COUNT;
                    end
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end
            COUNT: begin
                if (edge_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (edge_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
                // ro_en drops on entry to RESULT so the ROs stop right after the window
                if (timer_q == '0) begin
                    ro_en_d = 1'b0;
                    state_d = RESULT;
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end
            RESULT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                resp_d  = (cnt_a_q > cnt_b_q);
                tie_d   = (cnt_a_q == cnt_b_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            win_q     <= '0;
            ro_en_q   <= 1'b0;
            ro_c_q    <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            sync_a1_q <= 1'b0;
            sync_a2_q <= 1'b0;
            prev_a_q  <= 1'b0;
            sync_b1_q <= 1'b0;
            sync_b2_q <= 1'b0;
            prev_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            win_q     <= win_d;
            ro_en_q   <= ro_en_d;
            ro_c_q    <= ro_c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            sync_a1_q <= ro_a;
            sync_a2_q <= sync_a1_q;
            prev_a_q  <= sync_a2_q;
            sync_b1_q <= ro_b;
            sync_b2_q <= sync_b1_q;
            prev_b_q  <= sync_b2_q;
        end
    end

    assign ro_en = ro_en_q;
    assign ro_c  = ro_c_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign resp  = resp_q;
    assign tie   = tie_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_pair_counter.sv
// ============================================================================
// Module      : tb_ro_pair_counter
// Description : Directed self-checking bench for ro_pair_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_pair_counter;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  chal = 4'h0;
    logic [15:0] window = 16'd0;

    logic        ro_a = 1'b0, ro_b = 1'b0;
    logic        ro_en, busy, done, resp, tie;
    logic [3:0]  ro_c;
    logic [15:0] cnt_a, cnt_b;

    logic        ros_a = 1'b0, ros_b = 1'b0;
    logic        ro_en_s, busy_s, done_s, resp_s, tie_s;
    logic [3:0]  ro_c_s;
    logic [3:0]  cnt_a_s, cnt_b_s;

    int pa = 8, pb = 12;
    int ph_a = 0, ph_b = 0, phs_a = 0, phs_b = 0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    ro_pair_counter #(.CNT_W(16), .WIN_W(16), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chal(chal), .window(window),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .ro_c(ro_c), .busy(busy),
        .done(done), .resp(resp), .tie(tie), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_pair_counter #(.CNT_W(4), .WIN_W(16), .SETTLE(SETTLE)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .chal(chal), .window(window),
        .ro_a(ros_a), .ro_b(ros_b), .ro_en(ro_en_s), .ro_c(ro_c_s), .busy(busy_s),
        .done(done_s), .resp(resp_s), .tie(tie_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    // Ring-oscillator models: held low while disabled, square wave of period pa/pb when enabled
    always @(negedge clk) begin
        if (!ro_en) begin ph_a <= 0; ro_a <= 1'b0; ph_b <= 0; ro_b <= 1'b0; end
        else begin
            ph_a <= ph_a + 1; ro_a <= (((ph_a + 1) % pa) >= (pa / 2));
            ph_b <= ph_b + 1; ro_b <= (((ph_b + 1) % pb) >= (pb / 2));
        end
    end

    always @(negedge clk) begin
        if (!ro_en_s) begin phs_a <= 0; ros_a <= 1'b0; phs_b <= 0; ros_b <= 1'b0; end
        else begin
            phs_a <= phs_a + 1; ros_a <= (((phs_a + 1) % pa) >= (pa / 2));
            phs_b <= phs_b + 1; ros_b <= (((phs_b + 1) % pb) >= (pb / 2));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one start and wait for done; lat counts clock edges from the start edge
    task automatic run_meas(input logic [3:0] c, input logic [15:0] w,
                            output int lat, output int en_cyc, output bit roc_ok);
        @(negedge clk);
        start = 1'b1; chal = c; window = w;
        @(posedge clk); #1;
        start = 1'b0;
        en_cyc = ro_en ? 1 : 0;
        roc_ok = (ro_c === c) && busy;
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (ro_en) en_cyc++;
            if (busy && (ro_c !== c)) roc_ok = 1'b0;
            if (done) begin lat = n; break; end
        end
    endtask

    initial begin
        int  lat, en_cyc, cnt;
        bit  roc_ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ro_en", ro_en, 0);
        check("rst_ro_c",  ro_c, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_resp",  resp, 0);
        check("rst_tie",   tie, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic response: A faster than B
        pa = 8; pb = 12;
        run_meas(4'hA, 16'd96, lat, en_cyc, roc_ok);
        check("basic_latency", lat, SETTLE + 97);
        check("basic_ro_c_busy", roc_ok, 1);
        check("basic_cnt_a", (cnt_a >= 11 && cnt_a <= 13), 1);
        check("basic_cnt_b", (cnt_b >= 7 && cnt_b <= 9), 1);
        check("basic_resp", resp, 1);
        check("basic_tie", tie, 0);
        @(posedge clk); #1;
        check("basic_done_width", done, 0);
        check("basic_ro_c_hold", ro_c, 4'hA);
        check("basic_ro_en_off", ro_en, 0);

        // Tie: identical oscillators
        pa = 10; pb = 10;
        run_meas(4'h3, 16'd100, lat, en_cyc, roc_ok);
        check("tie_latency", lat, SETTLE + 101);
        check("tie_cnt_a", cnt_a, 10);
        check("tie_cnt_b", cnt_b, 10);
        check("tie_tie", tie, 1);
        check("tie_resp", resp, 0);

        // Zero-length window
        pa = 8; pb = 12;
        run_meas(4'h6, 16'd0, lat, en_cyc, roc_ok);
        check("w0_latency", lat, SETTLE + 1);
        check("w0_ro_en_cycles", en_cyc, SETTLE);
        check("w0_cnt_a", cnt_a, 0);
        check("w0_cnt_b", cnt_b, 0);
        check("w0_tie", tie, 1);
        check("w0_resp", resp, 0);
        repeat (3) @(posedge clk);

        // Handshake: starts during COUNT and during RESULT are ignored
        @(negedge clk);
        start = 1'b1; chal = 4'hA; window = 16'd40;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            if (n == 20 || n == SETTLE + 41) begin start = 1'b1; chal = 4'h3; window = 16'd2; end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin lat = n; break; end
        end
        check("hs_latency", lat, SETTLE + 41);
        check("hs_ro_c_kept", ro_c, 4'hA);
        check("hs_cnt_a", cnt_a, 5);
        cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        check("hs_no_extra_done", cnt, 0);

        // Back-to-back: start raised during the done cycle is accepted on the next edge
        run_meas(4'hA, 16'd40, lat, en_cyc, roc_ok);
        check("b2b_first_latency", lat, SETTLE + 41);
        check("b2b_first_cnt_a", cnt_a, 5);
        start = 1'b1; chal = 4'h5; window = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_ro_c", ro_c, 4'h5);
        check("b2b_cnt_a_clear", cnt_a, 0);
        check("b2b_cnt_b_clear", cnt_b, 0);
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        check("b2b_second_latency", lat, SETTLE + 9);
        repeat (3) @(posedge clk);

        // Saturation on the 4-bit instance
        pa = 4; pb = 6;
        run_meas(4'hC, 16'd200, lat, en_cyc, roc_ok);
        check("sat_done_s", done_s, 1);
        check("sat_cnt_a", cnt_a_s, 15);
        check("sat_cnt_b", cnt_b_s, 15);
        check("sat_tie", tie_s, 1);
        check("sat_resp", resp_s, 0);
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of COUNT
        pa = 8; pb = 12;
        @(negedge clk);
        start = 1'b1; chal = 4'h9; window = 16'd96;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_cnt_a_nonzero", (cnt_a != 0), 1);
        check("mid_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ro_en", ro_en, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cnt_a", cnt_a, 0);
        check("arst_cnt_b", cnt_b, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        check("arst_no_done", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Downstream measurement stage for a pair of 4-stage ring oscillators (RO cells with inputs en and c[3:0], output o).
- Enables both ROs with a shared challenge and counts rising edges of each RO output over a programmable gate window of system clocks.
- Compares the two counts and returns one PUF response bit, with both raw counts, through a start/done handshake.
- Sits between the challenge/response controller and the RO array.

Parameters:
- CNT_W, 16, width of each edge counter; counters saturate at all-ones.
- WIN_W, 16, width of the window input.
- SETTLE, 4, cycles ro_en is high before counting begins; legal range ≥3 (synchronizer fill).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- start  input  1  request a measurement; sampled only in IDLE.
- chal  input  4  challenge, captured on start acceptance.
- window  input  WIN_W  gate length in clk cycles, captured on start acceptance.
- ro_a  input  1  output o of RO A (asynchronous to clk).
- ro_b  input  1  output o of RO B (asynchronous to clk).
- ro_en  output  1  drives en of both ROs.
- ro_c  output  4  drives c[3:0] of both ROs.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse; results valid.
- resp  output  1  1 if cnt_a > cnt_b, else 0.
- tie  output  1  1 if cnt_a == cnt_b.
- cnt_a  output  CNT_W  edge count of RO A.
- cnt_b  output  CNT_W  edge count of RO B.

Behaviour:
- Reset state: FSM IDLE; ro_en=0, ro_c=0, busy=0, done=0, resp=0, tie=0, cnt_a=0, cnt_b=0; synchronizer and edge flops cleared.
- Input conditioning:
  - ro_a and ro_b each pass through a 2-flop synchronizer plus a previous-value flop.
  - edge = sync2 & ~prev.
  - Correct counting requires RO frequency < clk/2; faster oscillation aliases and is out of scope.
- FSM states: IDLE, ARM, COUNT, RESULT.
- IDLE:
  - On a clk edge with start=1: capture chal into ro_c and window into win_q; clear cnt_a/cnt_b; set ro_en=1, busy=1; load timer with SETTLE-1; go to ARM.
  - start=0: remain in IDLE.
- ARM:
  - Lasts exactly SETTLE cycles; edges are not counted.
  - When the timer reaches 0: if win_q==0 go to RESULT, else load timer with win_q-1 and go to COUNT.
- COUNT:
  - Lasts exactly win_q cycles.
  - Each cycle, cnt_a increments on edge_a and cnt_b on edge_b, each saturating at 2^CNT_W-1.
  - When the timer reaches 0, go to RESULT.
  - Edges detected in that final COUNT cycle are counted.
- RESULT (1 cycle):
  - ro_en=0, done=1, busy=0.
  - resp and tie registered from the final counts.
  - Go to IDLE.
- Outputs after done: cnt_a, cnt_b, resp, tie and ro_c hold until the next accepted start.
- Latency: start sampled at edge k gives done high during the cycle after edge k+SETTLE+win_q+1.
- Handshake:
  - start while busy=1 is ignored; no queuing.
  - start held high in the RESULT cycle is not accepted until IDLE (earliest the edge after done).
- Boundary cases:
  - window=0: no counting; cnt_a=cnt_b=0, tie=1, resp=0.
  - Both counters saturated: tie=1, resp=0.
  - Compare is unsigned.
- Reset mid-operation: rst_n low in any state immediately forces all reset values, including ro_en=0; no done is produced.
- ro_en is a registered output with no glitch at state transitions.

Test Plan:
- Reset check: assert rst_n=0 mid-COUNT. Required: ro_en, busy, done, cnt_a and cnt_b drop to 0 asynchronously, and no done follows the release of rst_n.
- Basic response:
  - Stimulus: ro_a period 8 clk, ro_b period 12 clk (bench models gated by ro_en), window=96, chal=4'hA.
  - Required: ro_c=4'hA while busy; cnt_a=12±1, cnt_b=8±1, resp=1, tie=0.
  - Required: done exactly SETTLE+97 cycles after the start edge, and 1 cycle wide.
- Tie: both ROs period 10 with identical phase, window=100. Required: cnt_a=cnt_b=10, tie=1, resp=0.
- Saturation: CNT_W=4, ro_a period 4, ro_b period 6, window=200. Required: cnt_a=15, cnt_b=15, tie=1, resp=0.
- window=0: Required: done SETTLE+1 cycles after start, counts 0, tie=1; ro_en high exactly SETTLE cycles.
- Handshake: pulse start again during COUNT and in the RESULT cycle. Required: ignored, with no extra done. Then start one cycle after done is accepted, and the counts clear on that edge.
